random_engine_ctrl: RTL and testbench

Control unit for the random engine datapath: accepts a val/rdy request for 1..8 pseudo-random bits, optionally reseeds the LFSR, steps it once per bit while shifting its serial output into a response word, and returns that word over a val/rdy response port. It sits between the engine's top-level request/response ports and the datapath. It owns `lfsr_en`, the datapath reset, and the registered tap/seed values driven into the datapath.

---
 rtl/random_engine_ctrl.sv | 101 ++++++++++
 tb/tb_random_engine_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/random_engine_ctrl.sv
// Control FSM for the random engine: accepts a 1..DATA_W bit request, optionally
// reseeds the datapath LFSR, shifts lfsr_out into a response word, and returns it.
module random_engine_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [3:0]        req_nbits,
  input  logic              req_reseed,
  input  logic [7:0]        req_tap,
  input  logic [7:0]        req_seed,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [DATA_W-1:0] resp_data,
  output logic [7:0]        dpath_tap,
  output logic [7:0]        dpath_seed,
  output logic              dpath_rst,
  output logic              lfsr_en,
  input  logic              lfsr_out
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SEED, GEN, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [CW-1:0]     nbits_eff;
  logic [DATA_W-1:0] shift;
  logic              accept;

  // A zero or oversize request asks for a full-width word.
  always_comb begin
    if (req_nbits == 4'd0 || 32'(req_nbits) > DATA_W) nbits_eff = CW'(DATA_W);
    else                                              nbits_eff = CW'(req_nbits);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake outputs depend on state only, never on req_val/resp_rdy.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    req_rdy    = 1'b0;
    resp_val   = 1'b0;
    lfsr_en    = 1'b0;
    dpath_rst  = rst;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          accept     = 1'b1;
          state_next = req_reseed ? SEED : GEN;
        end
      end
      SEED: begin
        dpath_rst  = 1'b1;
        state_next = GEN;
      end
      GEN: begin
        lfsr_en = 1'b1;
        if (count == CW'(1)) state_next = DONE;
      end
      DONE: begin
        resp_val = 1'b1;
        if (resp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dpath_tap  <= 8'hB8;
      dpath_seed <= 8'h01;
      count      <= '0;
      shift      <= '0;
    end else if (accept) begin
      dpath_tap <= req_tap;
      if (req_reseed) dpath_seed <= req_seed;
      count <= nbits_eff;
      shift <= '0;
    end else if (lfsr_en) begin
      // First sampled bit migrates up to bit n-1 after n shifts.
      shift <= {shift[DATA_W-2:0], lfsr_out};
      count <= count - CW'(1);
    end
  end

  assign resp_data = shift;

endmodule

// File: tb/tb_random_engine_ctrl.sv
// Bench for random_engine_ctrl: models a Galois LFSR datapath, runs a vector
// table through the controller and scores responses against a golden stream.
module tb_random_engine_ctrl;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              req_val;
  logic              req_rdy;
  logic [3:0]        req_nbits;
  logic              req_reseed;
  logic [7:0]        req_tap;
  logic [7:0]        req_seed;
  logic              resp_val;
  logic              resp_rdy;
  logic [DATA_W-1:0] resp_data;
  logic [7:0]        dpath_tap;
  logic [7:0]        dpath_seed;
  logic              dpath_rst;
  logic              lfsr_en;
  logic              lfsr_out;

  random_engine_ctrl #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_nbits  (req_nbits),
    .req_reseed (req_reseed),
    .req_tap    (req_tap),
    .req_seed   (req_seed),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_data  (resp_data),
    .dpath_tap  (dpath_tap),
    .dpath_seed (dpath_seed),
    .dpath_rst  (dpath_rst),
    .lfsr_en    (lfsr_en),
    .lfsr_out   (lfsr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] tap);
    return s[0] ? ((s >> 1) ^ tap) : (s >> 1);
  endfunction

  // Datapath stand-in: reloads from seed under dpath_rst, steps on lfsr_en.
  logic [7:0] lfsr_q;
  always @(posedge clk) begin
    if (dpath_rst)    lfsr_q <= dpath_seed;
    else if (lfsr_en) lfsr_q <= lfsr_step(lfsr_q, dpath_tap);
  end
  assign lfsr_out = lfsr_q[0];

  typedef struct {
    logic [3:0] nbits;
    logic       reseed;
    logic [7:0] tap;
    logic [7:0] seed;
    int         hold;
    int         exp_n;
    int         exp_lat;
  } vec_t;

  vec_t              vecs[7];
  logic [7:0]        g_state;
  logic [DATA_W-1:0] exp_q[$];
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_rdy();
    int w = 0;
    while (!req_rdy && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("req_rdy_before_req", req_rdy, 1);
  endtask

  task automatic scramble_req();
    req_val    = 1'b0;
    req_nbits  = 4'($urandom_range(15));
    req_reseed = 1'($urandom_range(1));
    req_tap    = 8'($urandom_range(255));
    req_seed   = 8'($urandom_range(255));
  endtask

  task automatic do_req(input vec_t v);
    logic [DATA_W-1:0] exp_d;
    logic [DATA_W-1:0] held;
    int cyc, en_cnt, rst_cnt, rdy_cnt;
    wait_rdy();
    if (v.reseed) g_state = v.seed;
    exp_d = '0;
    for (int i = 0; i < v.exp_n; i++) begin
      exp_d   = {exp_d[DATA_W-2:0], g_state[0]};
      g_state = lfsr_step(g_state, v.tap);
    end
    exp_q.push_back(exp_d);
    resp_rdy   = (v.hold == 0);
    req_val    = 1'b1;
    req_nbits  = v.nbits;
    req_reseed = v.reseed;
    req_tap    = v.tap;
    req_seed   = v.seed;
    @(posedge clk); #1;
    scramble_req();
    check("dpath_tap_latched", dpath_tap, v.tap);
    if (v.reseed) check("dpath_seed_latched", dpath_seed, v.seed);
    cyc = 0; en_cnt = 0; rst_cnt = 0; rdy_cnt = 0;
    while (!resp_val && cyc < 40) begin
      en_cnt  += int'(lfsr_en);
      rst_cnt += int'(dpath_rst);
      rdy_cnt += int'(req_rdy);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, v.exp_lat);
    check("lfsr_en_cycles", en_cnt, v.exp_n);
    check("dpath_rst_cycles", rst_cnt, v.reseed ? 1 : 0);
    check("req_rdy_busy", rdy_cnt, 0);
    held = resp_data;
    for (int i = 0; i < v.hold; i++) begin
      req_val = (i == 2);
      @(posedge clk); #1;
      check("hold_resp_val", resp_val, 1);
      check("hold_resp_data", resp_data, held);
      check("hold_lfsr_en", lfsr_en, 0);
      check("hold_req_rdy", req_rdy, 0);
    end
    req_val = 1'b0;
    if (v.hold > 0) check("hold_tap_unchanged", dpath_tap, v.tap);
    resp_rdy = 1'b1;
    check("resp_data", resp_data, exp_q.pop_front());
    @(posedge clk); #1;
    check("resp_val_after_hs", resp_val, 0);
    check("req_rdy_after_hs", req_rdy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0] = '{4'd8,  1'b1, 8'hB8, 8'h5A, 0, 8, 9};
    vecs[1] = '{4'd3,  1'b0, 8'hB8, 8'h00, 0, 3, 3};
    vecs[2] = '{4'd0,  1'b0, 8'hB8, 8'h00, 0, 8, 8};
    vecs[3] = '{4'd12, 1'b1, 8'h8E, 8'h3C, 0, 8, 9};
    vecs[4] = '{4'd1,  1'b0, 8'hE1, 8'h00, 0, 1, 1};
    vecs[5] = '{4'd5,  1'b1, 8'hB8, 8'hFF, 5, 5, 6};
    vecs[6] = '{4'd2,  1'b0, 8'h1D, 8'h00, 0, 2, 2};

    rst = 1'b1; resp_rdy = 1'b1;
    scramble_req();
    g_state = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dpath_rst", dpath_rst, 1);
    check("rst_resp_val", resp_val, 0);
    check("rst_lfsr_en", lfsr_en, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_dpath_tap", dpath_tap, 8'hB8);
    check("rst_dpath_seed", dpath_seed, 8'h01);
    rst = 1'b0;
    #1;
    check("idle_req_rdy", req_rdy, 1);
    check("idle_dpath_rst", dpath_rst, 0);

    for (int k = 0; k < 7; k++) do_req(vecs[k]);

    // Reset after 4 of 8 bits: request is dropped, no response ever appears.
    wait_rdy();
    req_val = 1'b1; req_nbits = 4'd8; req_reseed = 1'b0; req_tap = 8'hB8;
    @(posedge clk); #1;
    scramble_req();
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("midgen_lfsr_en", lfsr_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_req_rdy", req_rdy, 1);
    check("midrst_resp_val", resp_val, 0);
    check("midrst_lfsr_en", lfsr_en, 0);
    check("midrst_resp_data", resp_data, 0);
    check("midrst_dpath_tap", dpath_tap, 8'hB8);
    check("midrst_dpath_seed", dpath_seed, 8'h01);
    check("midrst_dpath_rst", dpath_rst, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    g_state = 8'h01;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      seen += int'(resp_val);
      @(posedge clk); #1;
    end
    check("midrst_no_resp", seen, 0);

    // Stream resumes from the reset seed.
    do_req('{4'd4, 1'b0, 8'hB8, 8'h00, 0, 4, 4});

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
